// File: rtl/bram_loader_pkg.sv
// rtl/bram_loader_pkg.sv - shared types and constants for the BRAM boot loader
// Purpose: loader FSM state encoding and header length shared by the
//          bram_loader slice.
// Contents: loader_state_t (IDLE, LEN, DATA, CHK, DONE), LEN_BYTES.
package bram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE
  } loader_state_t;

  // Header is a little-endian 16-bit word count.
  localparam int LEN_BYTES = 2;

endpackage

// File: rtl/bram_loader_byte_packer.sv
// rtl/bram_loader_byte_packer.sv - assembles bytes into little-endian words
// Purpose: counts accepted bytes and shifts them into a DW-bit word; after
//          DW/8 bytes emits a one-cycle registered word-valid pulse.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          discard any partial word (restart of a load)
//   i_valid        a byte is accepted this cycle
//   i_data         the accepted byte
//   o_word_valid   one-cycle pulse, o_word holds a complete word
//   o_word         assembled word, first byte in bits [7:0]
module byte_packer #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  output logic          o_word_valid,
  output logic [DW-1:0] o_word
);

  localparam int BPW = DW / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] word_q, word_d;
  logic          valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_valid) begin
      // New bytes enter at the top so the first byte ends up in [7:0].
      word_d = (word_q >> 8) | (DW'(i_data) << (DW - 8));
      if (cnt_q == CW'(BPW - 1)) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign o_word_valid = valid_q;
  assign o_word       = word_q;

endmodule

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - length-prefixed byte stream to BRAM write port loader
// Purpose: reads a 16-bit little-endian word count, then packs DW/8 bytes per
//          word and writes words to consecutive addresses from 0. Optional
//          trailing XOR checksum byte when BRAM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                begin a load (honoured in IDLE/DONE only)
//   i_rx_valid, i_rx_data  byte source; o_rx_ready accepts
//   o_we, o_waddr, o_wdata one-cycle registered write port
//   o_busy, o_done, o_error load status
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  output logic          o_rx_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);

  if (DW % 8 != 0 || DW < 8) begin : g_dw_bad
    $error("bram_loader: DW must be a multiple of 8 and at least 8");
  end
  if (AW < 1) begin : g_aw_bad
    $error("bram_loader: AW must be at least 1");
  end

  loader_state_t state_q, state_d;
  logic          len_idx_q, len_idx_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [AW:0]   nwords_q, nwords_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          active;
  logic          accept;
  logic          restart;
  logic          word_valid;
  logic [15:0]   len_word;
  logic          oversize;

  assign active     = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  // Ready drops while a word is being written so the strobe never overlaps a byte.
  assign o_rx_ready = active && !word_valid;
  assign accept     = i_rx_valid && o_rx_ready;
  assign restart    = i_start && ((state_q == IDLE) || (state_q == DONE));
  assign len_word   = {i_rx_data, len_lo_q};
  assign oversize   = {17'd0, len_word} > (33'd1 << AW);

  byte_packer #(.DW(DW)) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (restart),
    .i_valid      (accept && (state_q == DATA)),
    .i_data       (i_rx_data),
    .o_word_valid (word_valid),
    .o_word       (o_wdata)
  );

  always_comb begin
    state_d   = state_q;
    len_idx_d = len_idx_q;
    len_lo_d  = len_lo_q;
    nwords_d  = nwords_q;
    wcnt_d    = wcnt_q;
    waddr_d   = waddr_q;
    done_d    = done_q;
    error_d   = error_q;
`ifdef BRAM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d   = LEN;
          len_idx_d = 1'b0;
          wcnt_d    = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          if (int'(len_idx_q) != LEN_BYTES - 1) begin
            len_lo_d  = i_rx_data;
            len_idx_d = 1'b1;
          end else begin
            len_idx_d = 1'b0;
            nwords_d  = (AW + 1)'(len_word);
            if (len_word == 16'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (oversize) begin
              state_d = DONE;
              done_d  = 1'b1;
              error_d = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Address is the index of the word being assembled; stable until its strobe.
          waddr_d = wcnt_q[AW-1:0];
`ifdef BRAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ i_rx_data;
`endif
        end
        if (word_valid) begin
          wcnt_d = wcnt_q + (AW + 1)'(1);
          if (wcnt_d == nwords_q) begin
`ifdef BRAM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef BRAM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = DONE;
          done_d  = 1'b1;
          error_d = (i_rx_data != csum_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      len_idx_q <= 1'b0;
      len_lo_q  <= '0;
      nwords_q  <= '0;
      wcnt_q    <= '0;
      waddr_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_idx_q <= len_idx_d;
      len_lo_q  <= len_lo_d;
      nwords_q  <= nwords_d;
      wcnt_q    <= wcnt_d;
      waddr_q   <= waddr_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_we    = word_valid;
  assign o_waddr = waddr_q;
  assign o_busy  = active;
  assign o_done  = done_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_bram_loader.sv
// tb/tb_bram_loader.sv - scoreboard bench for bram_loader (DW=32, AW=2)
module tb_bram_loader;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int BPW = DW / 8;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  bram_loader #(.DW(DW), .AW(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_we       (we),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int            tests = 0;
  int            fails = 0;
  wr_t           exp_wr[$];
  logic          exp_err[$];
  logic [DW-1:0] mem_model[CAP];
  logic [DW-1:0] mem_dut[CAP];
  logic          done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops expected writes and results whenever the DUT presents them.
  always @(negedge clk) begin
    wr_t w;
    if (we) begin
      check("ready_low_in_write", rx_ready, 0);
      check("write_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("waddr", waddr, w.addr);
        check("wdata", wdata, w.data);
        mem_dut[waddr] = wdata;
      end
    end
    if (done && !done_prev) begin
      check("result_expected", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) check("error", err, exp_err.pop_front());
      check("writes_outstanding", exp_wr.size(), 0);
      check("busy_at_done", busy, 0);
    end
    done_prev = done;
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int budget;
    rx_valid = 1'b0;
    repeat (gap) begin
      if (noise && ($urandom_range(0, 3) == 0)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        rx_valid = 1'b0;
        break;
      end
      budget++;
      if (budget > 50) begin
        check("byte_accept_timeout", rx_ready, 1);
        rx_valid = 1'b0;
        break;
      end
    end
  endtask

  // Reference: header, words at 0..N-1 from little-endian byte groups,
  // XOR checksum byte when that feature is built in.
  task automatic do_load(input int n, input logic [7:0] data[$], input bit bad_chk, input bit noise);
    logic [7:0]    bytes[$];
    logic [7:0]    x;
    logic [DW-1:0] w;
    bit            e;
    int            budget;
    x = 8'h00;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    e = (n > CAP);
    if (n != 0 && !e) begin
      for (int k = 0; k < n; k++) begin
        w = '0;
        for (int j = 0; j < BPW; j++) begin
          w = w | (DW'(data[k*BPW+j]) << (8 * j));
          x = x ^ data[k*BPW+j];
          bytes.push_back(data[k*BPW+j]);
        end
        exp_wr.push_back('{addr: AW'(k), data: w});
        mem_model[k] = w;
      end
`ifdef BRAM_LOADER_CHECKSUM_EN
      bytes.push_back(bad_chk ? (x ^ 8'h01) : x);
      if (bad_chk) e = 1'b1;
`endif
    end
    exp_err.push_back(e);
    start_pulse();
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], noise ? $urandom_range(0, 2) : 0, noise && (i >= 2));
    budget = 0;
    while (!done && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    int         n;
    for (int i = 0; i < CAP; i++) begin
      mem_model[i] = '0;
      mem_dut[i]   = '0;
    end
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", rx_ready, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    @(posedge clk); #1;

    // Reset mid-DATA with half a word sent; nothing may be written.
    start_pulse();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'hAA, 0, 0);
    send_byte(8'hBB, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_we", we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", rx_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_error", err, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_write", we, 0);
    end
    @(posedge clk); #1;

    do_load(2, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 0, 0);
    do_load(0, '{}, 0, 0);
    do_load(5, '{}, 0, 0);
    d = {};
    for (int i = 0; i < CAP * BPW; i++) d.push_back(8'(i * 17 + 3));
    do_load(CAP, d, 0, 0);
`ifdef BRAM_LOADER_CHECKSUM_EN
    do_load(1, '{8'h01, 8'h02, 8'h04, 8'h08}, 0, 0);
    do_load(1, '{8'h01, 8'h02, 8'h04, 8'h08}, 1, 0);
`endif

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, CAP + 2);
      d = {};
      for (int i = 0; i < n * BPW; i++) d.push_back(8'($urandom));
      do_load(n, d, 1'($urandom_range(0, 1)), 1);
    end

    for (int i = 0; i < CAP; i++) check("mem_contents", mem_dut[i], mem_model[i]);
    check("results_left", exp_err.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
# bram_loader

Boot-time writer for on-chip block memory: consumes a length-prefixed byte stream from a byte source (e.g. UART receiver), assembles little-endian `DW`-bit words and drives a write port into the instruction/data BRAM. Sits between the serial front end and the memory's write port. Held in `DONE` until software or the boot sequencer restarts it.

## Interface
- `DW`, 32: memory word width in bits; multiple of 8, ≥ 8.
- `AW`, 10: memory address width; ≥ 1; capacity `2**AW` words.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_start`  in  1  begin a load; honoured only in `IDLE` or `DONE`.
- `i_rx_valid`  in  1  byte available on `i_rx_data`.
- `i_rx_data`  in  8  stream byte.
- `o_rx_ready`  out  1  loader accepts a byte this cycle.
- `o_we`  out  1  one-cycle write strobe.
- `o_waddr`  out  AW  write word address.
- `o_wdata`  out  DW  write word.
- `o_busy`  out  1  load in progress.
- `o_done`  out  1  load finished (level, held in `DONE`).
- `o_error`  out  1  load failed (level, valid while `o_done`).

## Operation
- Byte accepted when `i_rx_valid && o_rx_ready`.
- States: `IDLE` → (`i_start`) `LEN` → `DATA` → [`CHK`] → `DONE` → (`i_start`) `LEN`.
- `LEN`: 2 bytes, little-endian 16-bit word count N. If N == 0 → `DONE`, no writes, no error. If N > `2**AW` → `DONE`, `o_error`=1, no writes.
- `DATA`: bytes packed little-endian (first byte → bits [7:0]); after `DW/8` bytes a write is issued at address = word index, starting at 0, incrementing by 1. After N words → `CHK` (macro on) or `DONE`.
- Word counter is `AW+1` bits so N = `2**AW` terminates correctly; address never wraps.
- `i_start` while busy: ignored. `i_start` in `DONE`: clears `o_done`/`o_error`, counters, checksum; enters `LEN`.
- Reset mid-operation: immediate return to `IDLE`, partial word discarded, no write strobe.

## Timing
- Reset values: `o_rx_ready`=0, `o_we`=0, `o_waddr`=0, `o_wdata`=0, `o_busy`=0, `o_done`=0, `o_error`=0.
- `o_rx_ready` = 1 in `LEN`, `DATA`, `CHK`; 0 in `IDLE`, `DONE`, and in the cycle `o_we` is high (one-cycle write bubble).
- `o_we`, `o_waddr`, `o_wdata` registered: valid the cycle after the last byte of a word is accepted, for exactly one cycle.
- `o_busy` = 1 from the cycle after `i_start` until entering `DONE`.
- `o_done` rises the cycle after the final write strobe (or the final header/checksum byte when no write follows it).
- Minimum throughput: `DW/8`+1 cycles per word with `i_rx_valid` held high.

## Configuration
- `BRAM_LOADER_CHECKSUM_EN` defined: after N words, state `CHK` accepts one byte; it must equal XOR of all data bytes (header excluded). Mismatch → `o_error`=1 in `DONE`. Words already written stay written. Not applicable for N == 0 or oversize N (no checksum byte consumed).
- Not defined: no `CHK` state; `DATA` → `DONE`; `o_error` only from oversize N.

## Structure
- Shared package `bram_loader_pkg`: state enum `loader_state_t` (`IDLE`, `LEN`, `DATA`, `CHK`, `DONE`), `LEN_BYTES` = 2.
- One sub-module natural: `byte_packer` (byte counter + shift register, emits word-valid pulse).
- Parameter checks: `$error` on `DW` % 8 ≠ 0, `DW` < 8, `AW` < 1.

## Test plan
- Reset mid-`DATA` (DW=32, 2 of 4 bytes sent) -> all outputs 0, state `IDLE`, no `o_we`; fresh load then writes address 0.
- N=2, bytes 02 00 | 11 22 33 44 | 55 66 77 88 -> writes 0x44332211 @0, 0x88776655 @1; `o_done`=1, `o_error`=0.
- N=0 (00 00) -> `o_done`=1, `o_error`=0, zero writes; next `i_start` re-enters `LEN`.
- AW=2, N=5 (05 00) -> `o_done`=1, `o_error`=1, zero writes; N=4 full fill writes @0..3, no wrap.
- Checksum on, N=1, data 01 02 04 08, check byte 0x0F -> no error; check byte 0x0E -> `o_error`=1, word still written.
- Random `i_rx_valid` gaps and `i_start` pulses during `DATA` -> identical memory contents, `i_start` ignored.
